// File: rtl/pattern_scan_scheduler.sv
// Round-robin front end that time-shares one bit-serial Mealy detector
// between N_REQ word producers and reports the match count per word.
module pattern_scan_scheduler #(
  parameter int N_REQ  = 4,
  parameter int WORD_W = 8,
  parameter int ID_W   = 2,
  parameter int CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*WORD_W-1:0] data,
  output logic [N_REQ-1:0]        ack,
  output logic                    det_reset,
  output logic                    det_in,
  input  logic                    det_out,
  output logic                    res_valid,
  output logic [ID_W-1:0]         res_id,
  output logic [CNT_W-1:0]        res_count,
  output logic                    busy
);

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_DRAIN,
    S_REPORT
  } state_t;

  state_t              r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_id;
  logic [WORD_W-1:0]   r_sr;
  logic [CNT_W-1:0]    r_cnt;
  logic [BIT_W-1:0]    r_bit;
  logic [N_REQ-1:0]    r_ack;
  logic                r_res_valid;
  logic [ID_W-1:0]     r_res_id;
  logic [CNT_W-1:0]    r_res_count;

  logic                w_any;
  logic [ID_W-1:0]     w_id;
  logic [ID_W-1:0]     w_nxt;
  logic [WORD_W-1:0]   w_word;

  // Scan offsets high to low so the smallest offset from r_ptr wins.
  always_comb begin
    int j;
    j      = 0;
    w_any  = 1'b0;
    w_id   = '0;
    w_nxt  = '0;
    w_word = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(r_ptr) + k) % N_REQ;
      if (req[j]) begin
        w_any  = 1'b1;
        w_id   = ID_W'(j);
        w_nxt  = ID_W'((j + 1) % N_REQ);
        w_word = data[j*WORD_W +: WORD_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_ack       <= '0;
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_count <= '0;
    end else begin
      r_ack       <= '0;
      r_res_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_sr    <= w_word;
            r_id    <= w_id;
            r_cnt   <= '0;
            r_ptr   <= w_nxt;
            r_ack   <= N_REQ'(1) << w_id;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_bit   <= '0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_sr <= r_sr << 1;
          // First sample still reflects the CLEAR cycle, not our data.
          if (r_bit != '0) begin
            r_cnt <= r_cnt + CNT_W'(det_out);
          end
          if (r_bit == BIT_W'(WORD_W - 1)) begin
            r_state <= S_DRAIN;
          end else begin
            r_bit <= r_bit + BIT_W'(1);
          end
        end
        S_DRAIN: begin
          r_res_count <= r_cnt + CNT_W'(det_out);
          r_res_id    <= r_id;
          r_res_valid <= 1'b1;
          r_state     <= S_REPORT;
        end
        S_REPORT: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ack       = r_ack;
  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign res_count = r_res_count;
  assign busy      = (r_state != S_IDLE);
  assign det_in    = (r_state == S_SHIFT) & r_sr[WORD_W-1];
  assign det_reset = reset | (r_state == S_CLEAR);

endmodule

// File: tb/tb_pattern_scan_scheduler.sv
// Directed bench for pattern_scan_scheduler with a falling-edge detector
// model and an ack/result scoreboard.
module tb_pattern_scan_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  ack;
  logic        det_reset;
  logic        det_in;
  logic        det_out;
  logic        res_valid;
  logic [1:0]  res_id;
  logic [3:0]  res_count;
  logic        busy;

  logic        force1;
  logic        dq;
  logic        prev;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] cnt;
  } res_t;

  int   exp_ack[$];
  res_t exp_res[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_ack = 0;
  int   last_burst = 0;
  int   burst = 0;
  bit   in_flight = 0;

  always #5 clk = ~clk;

  pattern_scan_scheduler #(
    .N_REQ(4), .WORD_W(8), .ID_W(2), .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .data(data),
    .ack(ack),
    .det_reset(det_reset),
    .det_in(det_in),
    .det_out(det_out),
    .res_valid(res_valid),
    .res_id(res_id),
    .res_count(res_count),
    .busy(busy)
  );

  // Detector: registered 1 when bit is 0 and the previous bit was 1.
  always @(posedge clk) begin
    if (det_reset) begin
      dq   <= 1'b0;
      prev <= 1'b0;
    end else begin
      dq   <= prev & ~det_in;
      prev <= det_in;
    end
  end
  assign det_out = force1 | dq;

  task automatic chk(input bit ok, input string nm,
                     input int act, input int want);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)",
               nm, act, want, cyc);
    end
  endtask

  task automatic monitor();
    int   e;
    res_t r;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        in_flight  = 0;
        last_burst = 0;
      end else begin
        if (ack != 4'b0) begin
          chk(exp_ack.size() != 0, "ack_expected", ack, 0);
          if (exp_ack.size() != 0) begin
            e = exp_ack.pop_front();
            chk(ack == 4'(1 << e), "ack_onehot", ack, 1 << e);
          end
          chk(det_reset && !det_in && busy, "clear_cycle",
              {busy, det_reset, det_in}, 3'b110);
          if (burst != 0 && last_burst == burst) begin
            chk(cyc - last_ack == 12, "grant_spacing",
                cyc - last_ack, 12);
          end
          last_ack   = cyc;
          last_burst = burst;
          in_flight  = 1;
        end else if (in_flight) begin
          chk(busy && !det_reset, "busy_scan",
              {busy, det_reset}, 2'b10);
        end
        if (res_valid) begin
          chk(exp_res.size() != 0, "res_expected",
              {res_id, res_count}, 0);
          if (exp_res.size() != 0) begin
            r = exp_res.pop_front();
            chk(res_id == r.id && res_count == r.cnt, "result",
                {res_id, res_count}, r);
          end
          chk(cyc - last_ack == 10, "ack_to_res", cyc - last_ack, 10);
          in_flight = 0;
        end
      end
    end
  endtask

  task automatic wait_ack(output int id);
    bit got;
    got = 0;
    id  = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (ack != 4'b0) begin
        got = 1;
        for (int b = 0; b < 4; b++) if (ack[b]) id = b;
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL ack_wait: got no ack, want one within 60 cycles");
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = (exp_ack.size() == 0) && (exp_res.size() == 0) && !busy;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d acks %0d results pending, want 0",
               exp_ack.size(), exp_res.size());
      exp_ack.delete();
      exp_res.delete();
    end
    @(negedge clk);
  endtask

  task automatic push(input int id, input int cnt);
    exp_ack.push_back(id);
    exp_res.push_back(res_t'({2'(id), 4'(cnt)}));
  endtask

  initial begin
    int id;
    int seen[4];
    reset  = 1'b1;
    req    = 4'b0;
    data   = 32'h0;
    force1 = 1'b0;
    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    chk(ack == 4'b0, "rst_ack", ack, 0);
    chk(det_in == 1'b0, "rst_det_in", det_in, 0);
    chk(det_reset == 1'b1, "rst_det_reset", det_reset, 1);
    chk(res_valid == 1'b0, "rst_res_valid", res_valid, 0);
    chk(res_id == 2'd0, "rst_res_id", res_id, 0);
    chk(res_count == 4'd0, "rst_res_count", res_count, 0);
    chk(busy == 1'b0, "rst_busy", busy, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Round-robin order from ptr=0
    burst = 1;
    data = {8'h55, 8'hAA, 8'h00, 8'hFF};
    push(0, 0); push(1, 0); push(2, 4); push(3, 3);
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_ack(id);
      @(posedge clk); #1 req[id] = 1'b0;
    end
    wait_idle();

    // Fairness: 0 and 2 held continuously
    burst = 2;
    seen = '{0, 0, 0, 0};
    data[7:0]   = 8'hF0;
    data[23:16] = 8'h66;
    push(0, 1); push(2, 2); push(0, 1); push(2, 1);
    req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      wait_ack(id);
      @(posedge clk); #1;
      if (seen[id] == 0) begin
        if (id == 0) data[7:0] = 8'h81;
        else data[23:16] = 8'h0C;
      end else begin
        req[id] = 1'b0;
      end
      seen[id]++;
    end
    wait_idle();
    burst = 0;

    // Single word
    data[7:0] = 8'hA5;
    push(0, 3);
    req = 4'b0001;
    wait_ack(id);
    @(posedge clk); #1 req = 4'b0;
    wait_idle();

    // Detector cleared per word
    data[7:0] = 8'h01;
    push(0, 0); push(0, 0);
    req = 4'b0001;
    wait_ack(id);
    @(posedge clk); #1 data[7:0] = 8'h00;
    wait_ack(id);
    @(posedge clk); #1 req = 4'b0;
    wait_idle();

    // Sampling window with det_out stuck high
    force1 = 1'b1;
    data[15:8] = 8'h3C;
    push(1, 8);
    req = 4'b0010;
    wait_ack(id);
    @(posedge clk); #1 req = 4'b0;
    wait_idle();
    force1 = 1'b0;

    // Reset in the 4th SHIFT cycle, ptr=2
    data[15:8] = 8'h5A;
    exp_ack.push_back(1);
    req = 4'b0010;
    wait_ack(id);
    @(posedge clk); #1 req = 4'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk(busy == 1'b0, "abort_busy", busy, 0);
    chk(det_in == 1'b0, "abort_det_in", det_in, 0);
    chk(det_reset == 1'b1, "abort_det_reset", det_reset, 1);
    chk(ack == 4'b0, "abort_ack", ack, 0);
    chk(res_valid == 1'b0, "abort_res_valid", res_valid, 0);
    chk({res_id, res_count} == 6'd0, "abort_res",
        {res_id, res_count}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (15) @(negedge clk);

    data[7:0]   = 8'h90;
    data[23:16] = 8'h09;
    push(0, 2); push(2, 1);
    req = 4'b0101;
    wait_ack(id);
    @(posedge clk); #1 req[id] = 1'b0;
    wait_ack(id);
    @(posedge clk); #1 req[id] = 1'b0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
